qcs_clk_div_gen: RTL
====================

QCS_CLK_DIV_GEN -- requirements
Module: qcs_clk_div_gen

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divided-clock channels (1..16).
REQ-002 Parameter DIV_W, default 8: width of each channel divide ratio.
REQ-003 clk  input  1  single block clock; all logic on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ch_en  input  NUM_CH  per-channel run enable, level-sensitive.
REQ-006 cfg_vld  input  1  divide-ratio update request.
REQ-007 cfg_ch  input  max(1,$clog2(NUM_CH))  target channel of the update.
REQ-008 cfg_div  input  DIV_W  new divide ratio D.
REQ-009 cfg_rdy  output  1  update accepted when cfg_vld && cfg_rdy.
REQ-010 clk_out  output  NUM_CH  registered divided clock per channel.
REQ-011 tick  output  NUM_CH  registered one-cycle pulse marking the first cycle of each clk_out period.
REQ-012 sync_req  input  1  global phase-realign pulse (present only with QCS_CLK_DIV_GEN_SYNC_EN).

Function
REQ-013 Each channel SHALL hold state OFF or RUN, a cycle counter cnt (0..D-1), active ratio D and pending ratio P with pend flag.
REQ-014 OFF->RUN when ch_en[i]=1 and D>=1; first RUN cycle has cnt=0, clk_out[i]=1, tick[i]=1, one cycle after ch_en rises.
REQ-015 In RUN, cnt SHALL increment each cycle and wrap D-1->0; tick[i]=1 exactly when cnt=0.
REQ-016 clk_out[i] SHALL be 1 for cnt < ceil(D/2), else 0; period exactly D cycles; D=1 gives clk_out held 1 and tick every cycle.
REQ-017 D=0 SHALL force channel to OFF; ch_en ignored until a non-zero ratio is applied.
REQ-018 ch_en[i] deassert in RUN: channel SHALL complete the current period, enter OFF at wrap instead of cnt=0; no truncated high phase.
REQ-019 ch_en[i] reasserted before that wrap: channel SHALL stay in RUN with no gap.
REQ-020 In OFF, clk_out[i]=0, tick[i]=0, cnt=0.
REQ-021 cfg_rdy SHALL be 0 when channel cfg_ch has pend=1, else 1 (combinational on cfg_ch).
REQ-022 Accepted update to an OFF channel SHALL load D directly next cycle; to a RUN channel SHALL set P/pend and apply at the next wrap (that period's cnt=0 uses new D), clearing pend.
REQ-023 cfg_ch >= NUM_CH SHALL be accepted (cfg_rdy=1) and dropped.
REQ-024 Simultaneous wrap and new update on same channel: pend=1 blocks acceptance, so no overlap; update to a channel whose ch_en falls SHALL apply when it enters OFF.

Reset
REQ-025 rst SHALL force all channels OFF, cnt=0, D=0, pend=0, clk_out=0, tick=0; cfg_rdy=1 from the first post-reset cycle.
REQ-026 rst asserted mid-period SHALL abort immediately; no completion of the period.

Configuration
REQ-027 Macro QCS_CLK_DIV_GEN_SYNC_EN defined: sync_req port exists; sync_req=1 SHALL force every RUN channel to cnt=0 next cycle (tick=1, clk_out=1), applying any pending ratio at that point; OFF channels unaffected.
REQ-028 Macro undefined: no sync_req port, no related logic; behaviour otherwise identical.

Structure
REQ-029 Package qcs_clk_div_gen_pkg SHALL hold channel-state enum (OFF, RUN) and MAX_NUM_CH=16 constant.
REQ-030 Per-channel logic SHALL be sub-module qcs_clk_div_ch, generated NUM_CH times; top holds config decode and cfg_rdy mux.

Verification
REQ-031 Reset, cfg ch0 D=4, ch_en[0]=1 at cycle t -> tick[0] at t+1,t+5,t+9; clk_out[0] pattern 1100 repeating.
REQ-032 ch1 D=5 running, ch_en[1]=0 at cnt=1 -> clk_out 1,1,1,0,0 completes, then OFF; no further ticks.
REQ-033 ch2 D=3 running, cfg D=6 at cnt=1 -> cfg_rdy=0 for ch2 until wrap; next period 6 cycles (111000).
REQ-034 cfg D=0 to running ch3 -> channel finishes period, goes OFF; ch_en[3]=1 keeps it OFF.
REQ-035 SYNC_EN: ch0 D=4, ch1 D=6 at differing phases, sync_req pulse at t -> tick[0] and tick[1] both at t+1.
REQ-036 rst pulse mid-period with pend=1 -> all outputs 0 next cycle, pend cleared, cfg_rdy=1.

Source files
------------

// File: rtl/qcs_clk_div_gen_pkg.sv
// Shared types and constants for the qcs_clk_div_gen multi-channel clock divider.
// Optional phase-realign feature: QCS_CLK_DIV_GEN_SYNC_EN.
package qcs_clk_div_gen_pkg;

  localparam int MAX_NUM_CH = 16;

  typedef enum logic {
    CH_OFF = 1'b0,
    CH_RUN = 1'b1
  } ch_state_e;

  // Channel-select width; a single channel still needs one select bit.
  function automatic int cfg_ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/qcs_clk_div_gen_if.sv
// Divide-ratio configuration handshake for qcs_clk_div_gen.
// Unaffected by QCS_CLK_DIV_GEN_SYNC_EN.
interface qcs_clk_div_gen_if
  import qcs_clk_div_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
);

  localparam int CH_W = cfg_ch_w(NUM_CH);

  logic            cfg_vld;
  logic [CH_W-1:0] cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic            cfg_rdy;

  modport master (output cfg_vld, output cfg_ch, output cfg_div, input cfg_rdy);
  modport slave  (input cfg_vld, input cfg_ch, input cfg_div, output cfg_rdy);

endinterface

// File: rtl/qcs_clk_div_ch.sv
// One divided-clock channel: OFF/RUN state, period counter, active and pending ratio.
// With QCS_CLK_DIV_GEN_SYNC_EN a sync input restarts a running period.
module qcs_clk_div_ch
  import qcs_clk_div_gen_pkg::*;
#(
  parameter int DIV_W = 8
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             upd,
  input  logic [DIV_W-1:0] upd_div,
`ifdef QCS_CLK_DIV_GEN_SYNC_EN
  input  logic             sync,
`endif
  output logic             pend,
  output logic             clk_out,
  output logic             tick
);

  localparam int HW = DIV_W + 1;

  ch_state_e        state_r, state_nxt_s;
  logic [DIV_W-1:0] cnt_r, cnt_nxt_s;
  logic [DIV_W-1:0] div_r, div_nxt_s;
  logic [DIV_W-1:0] pdiv_r, pdiv_nxt_s;
  logic             pend_r, pend_nxt_s;
  logic             clk_out_r, clk_nxt_s;
  logic             tick_r, tick_nxt_s;
  logic             wrap_s, restart_s;
  logic [DIV_W-1:0] eff_div_s;
  logic [HW-1:0]    half_s;

  // Next-state, next-count, ratio bookkeeping and next registered outputs.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    div_nxt_s   = div_r;
    pdiv_nxt_s  = pdiv_r;
    pend_nxt_s  = pend_r;
    wrap_s      = (cnt_r == (div_r - DIV_W'(1)));
`ifdef QCS_CLK_DIV_GEN_SYNC_EN
    restart_s   = wrap_s | sync;
`else
    restart_s   = wrap_s;
`endif
    eff_div_s   = pend_r ? pdiv_r : div_r;

    case (state_r)
      CH_OFF: begin
        cnt_nxt_s = '0;
        if (upd) begin
          div_nxt_s = upd_div;
        end else if (en && (div_r != '0)) begin
          state_nxt_s = CH_RUN;
        end else begin
          state_nxt_s = CH_OFF;
        end
      end
      CH_RUN: begin
        if (restart_s) begin
          cnt_nxt_s  = '0;
          div_nxt_s  = eff_div_s;
          pend_nxt_s = 1'b0;
          // Enable is only honoured at a natural wrap so no period is cut short.
          if ((eff_div_s == '0) || (wrap_s && !en)) begin
            state_nxt_s = CH_OFF;
          end else begin
            state_nxt_s = CH_RUN;
          end
        end else begin
          cnt_nxt_s = cnt_r + DIV_W'(1);
        end
        if (upd) begin
          if (state_nxt_s == CH_OFF) begin
            div_nxt_s = upd_div;
          end else begin
            pend_nxt_s = 1'b1;
            pdiv_nxt_s = upd_div;
          end
        end else begin
          pdiv_nxt_s = pdiv_r;
        end
      end
      default: begin
        state_nxt_s = CH_OFF;
        cnt_nxt_s   = '0;
      end
    endcase

    half_s     = ({1'b0, div_nxt_s} + HW'(1)) >> 1;
    clk_nxt_s  = (state_nxt_s == CH_RUN) && ({1'b0, cnt_nxt_s} < half_s);
    tick_nxt_s = (state_nxt_s == CH_RUN) && (cnt_nxt_s == '0);
  end

  // Channel state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= CH_OFF;
      cnt_r     <= '0;
      div_r     <= '0;
      pdiv_r    <= '0;
      pend_r    <= 1'b0;
      clk_out_r <= 1'b0;
      tick_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      div_r     <= div_nxt_s;
      pdiv_r    <= pdiv_nxt_s;
      pend_r    <= pend_nxt_s;
      clk_out_r <= clk_nxt_s;
      tick_r    <= tick_nxt_s;
    end
  end

  assign pend    = pend_r;
  assign clk_out = clk_out_r;
  assign tick    = tick_r;

endmodule

// File: rtl/qcs_clk_div_gen.sv
// Multi-channel programmable clock divider: config decode, ready mux, channel array.
// Define QCS_CLK_DIV_GEN_SYNC_EN to add the sync_req phase-realign input.
module qcs_clk_div_gen
  import qcs_clk_div_gen_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
`ifdef QCS_CLK_DIV_GEN_SYNC_EN
  input  logic              sync_req,
`endif
  qcs_clk_div_gen_if.slave  cfg,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam int CH_W  = cfg_ch_w(NUM_CH);
  localparam int PAD_N = 2 ** CH_W;

  logic [NUM_CH-1:0] pend_s;
  logic [NUM_CH-1:0] upd_s;
  logic [PAD_N-1:0]  pend_pad_s;
  logic              cfg_rdy_s;
  logic              accept_s;

  // Unpopulated select codes read as never-pending, so they are accepted and dropped.
  always_comb begin
    pend_pad_s = PAD_N'(pend_s);
    cfg_rdy_s  = ~pend_pad_s[cfg.cfg_ch];
    accept_s   = cfg.cfg_vld & cfg_rdy_s;
  end

  assign cfg.cfg_rdy = cfg_rdy_s;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign upd_s[i] = accept_s && (cfg.cfg_ch == CH_W'(i));

    qcs_clk_div_ch #(.DIV_W(DIV_W)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (ch_en[i]),
      .upd     (upd_s[i]),
      .upd_div (cfg.cfg_div),
`ifdef QCS_CLK_DIV_GEN_SYNC_EN
      .sync    (sync_req),
`endif
      .pend    (pend_s[i]),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

endmodule
